// File: rtl/stim_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stim_chk_pkg
// Description : Shared types and constants for the stimulus sequence checker.
//               Holds the checker state enum, the default expected sequence,
//               the error-counter saturation limit and small helper functions.
// Revision    : 1.0  initial release
// ============================================================================
package stim_chk_pkg;

    // Checker run states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Geometry of the default expected sequence.
    localparam int DEF_DW    = 4;
    localparam int DEF_DEPTH = 3;

    // Default expected sequence. Element 0 sits in the least significant
    // slice and is checked first, so the stream order is 0000, 0011, 1100.
    localparam logic [DEF_DEPTH-1:0][DEF_DW-1:0] DEF_SEQ =
        {4'b1100, 4'b0011, 4'b0000};

    // Mismatch counter saturation limit.
    localparam logic [7:0] ERR_SAT = 8'd255;

    // Width of a sample index; a single-entry sequence still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Saturating increment of the mismatch counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stim_seq_checker_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : idle_timer
// Description : Counts consecutive idle cycles for the sequence checker and
//               flags when the count reaches TIMEOUT-1.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               clear    - synchronous clear of the idle count
//               count_en - advance the idle count this cycle
//               expired  - idle count equals TIMEOUT-1
// Revision    : 1.0  initial release
// ============================================================================
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int c_tw = $clog2(TIMEOUT);
    localparam logic [c_tw-1:0] c_limit = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_timer;

    // The checker leaves RUN on the idle cycle seen while expired is high,
    // so the hold at the limit only guards against wrap if that ever changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (clear) begin
            r_timer <= '0;
        end else if (count_en && !expired) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign expired = (r_timer == c_limit);

endmodule
`default_nettype wire

// File: rtl/stim_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : stim_seq_checker
// Description : Receiving end of the bench stimulus path. Compares each valid
//               DW-bit sample, in order, with a fixed expected sequence,
//               counts mismatches, detects stalled streams with an idle
//               timeout and reports a single pass/fail verdict.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               start        - begin/restart a run (ignored while running)
//               in_valid     - qualifies in_data
//               in_data      - sample under test
//               busy         - run in progress
//               done         - run finished, verdict valid
//               pass         - no mismatches and no timeout (only when done)
//               timeout      - run ended because the stream went idle
//               mismatch     - one-cycle pulse per mismatching sample
//               mismatch_idx - index of the most recent mismatch
//               err_cnt      - mismatch count, saturating at 255
// Revision    : 1.0  initial release
// ============================================================================
module stim_seq_checker
    import stim_chk_pkg::*;
#(
    parameter int                          DW      = 4,
    parameter int                          DEPTH   = 3,
    parameter logic [DEPTH-1:0][DW-1:0]    EXP_SEQ = DEF_SEQ,
    parameter int                          TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DW-1:0]                 in_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic                          mismatch,
    output logic [idx_width(DEPTH)-1:0]   mismatch_idx,
    output logic [7:0]                    err_cnt
);

    localparam int              c_iw   = idx_width(DEPTH);
    localparam logic [c_iw-1:0] c_last = c_iw'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    chk_state_t      r_state;
    logic [c_iw-1:0] r_idx;
    logic [7:0]      r_err_cnt;
    logic            r_timeout;
    logic [c_iw-1:0] r_mismatch_idx;
    logic            r_mismatch;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    chk_state_t      w_state_nxt;
    logic [c_iw-1:0] w_idx_nxt;
    logic [7:0]      w_err_nxt;
    logic            w_to_nxt;
    logic [c_iw-1:0] w_midx_nxt;

    logic            w_in_run;
    logic            w_miss;
    logic            w_expired;
    logic            w_tmr_clr;
    logic            w_tmr_cnt;

    assign w_in_run = (r_state == RUN);

    // Four-state compare: any X/Z bit on the sample counts as a mismatch.
    assign w_miss = w_in_run && in_valid && (in_data !== EXP_SEQ[r_idx]);

    // The idle count only advances on idle RUN cycles. Holding it clear
    // everywhere else guarantees every run starts from zero.
    assign w_tmr_clr = !w_in_run || in_valid;
    assign w_tmr_cnt = w_in_run && !in_valid;

    idle_timer #(
        .TIMEOUT  (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_tmr_clr),
        .count_en (w_tmr_cnt),
        .expired  (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err_cnt;
        w_to_nxt    = r_timeout;
        w_midx_nxt  = r_mismatch_idx;

        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                    w_err_nxt   = '0;
                    w_to_nxt    = 1'b0;
                    w_midx_nxt  = '0;
                end
            end

            RUN: begin
                // A sample on the cycle the timer would expire wins.
                if (in_valid) begin
                    if (w_miss) begin
                        w_midx_nxt = r_idx;
                        w_err_nxt  = sat_inc(r_err_cnt);
                    end
                    if (r_idx == c_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt = DONE;
                    w_to_nxt    = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next-state values so that they
    // change on the same edge as the state itself, without decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_err_cnt      <= '0;
            r_timeout      <= 1'b0;
            r_mismatch_idx <= '0;
            r_mismatch     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_err_cnt      <= w_err_nxt;
            r_timeout      <= w_to_nxt;
            r_mismatch_idx <= w_midx_nxt;
            r_mismatch     <= w_miss;
            r_busy         <= (w_state_nxt == RUN);
            r_done         <= (w_state_nxt == DONE);
            r_pass         <= (w_state_nxt == DONE) && (w_err_nxt == 8'd0)
                              && !w_to_nxt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire
